// File: rtl/egress_reader.sv
// Read-side consumer for the two destination FIFOs: round-robin pop generation,
// word capture onto one egress port, and tag/sequence checking per destination.
module egress_reader #(
   parameter int DATA_W = 6,
   parameter int CNT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              empty_D0,
   input  logic              empty_D1,
   input  logic [DATA_W-1:0] data_out0,
   input  logic [DATA_W-1:0] data_out1,
   output logic              pop_D0,
   output logic              pop_D1,
   output logic [DATA_W-1:0] data_rx,
   output logic              valid_rx,
   output logic              dest_rx,
   output logic [CNT_W-1:0]  rx_count0,
   output logic [CNT_W-1:0]  rx_count1,
   output logic [CNT_W-1:0]  err_count,
   output logic              error_rx,
   output logic              idle_rd
);

   typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

   state_t            state, state_nx;
   logic              pop0_nx, pop1_nx, idle_nx;
   logic              elig0, elig1, in_flight;
   logic              last_grant;
   logic [3:0]        exp_seq0, exp_seq1;
   logic [DATA_W-1:0] word;
   logic [3:0]        exp_sel;
   logic              sel, word_bad;

   // A FIFO popped last cycle still shows a stale empty flag, so skip it once.
   assign elig0     = !empty_D0 && !pop_D0;
   assign elig1     = !empty_D1 && !pop_D1;
   assign in_flight = pop_D0 || pop_D1;

   assign sel      = pop_D1;
   assign word     = pop_D1 ? data_out1 : data_out0;
   assign exp_sel  = pop_D1 ? exp_seq1 : exp_seq0;
   assign word_bad = (word[4] != sel) || (word[3:0] != exp_sel);

   always_comb begin
      state_nx = state;
      pop0_nx  = 1'b0;
      pop1_nx  = 1'b0;
      case (state)
         IDLE: if (enable) state_nx = RUN;
         RUN: begin
            if (!enable) begin
               state_nx = STOP;
            end else if (elig0 && elig1) begin
               if (last_grant) pop0_nx = 1'b1;
               else            pop1_nx = 1'b1;
            end else if (elig0) begin
               pop0_nx = 1'b1;
            end else if (elig1) begin
               pop1_nx = 1'b1;
            end
         end
         STOP: if (!in_flight) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      idle_nx = (state_nx == IDLE) ||
                ((state_nx == RUN) && !pop0_nx && !pop1_nx && !in_flight &&
                 empty_D0 && empty_D1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         pop_D0     <= 1'b0;
         pop_D1     <= 1'b0;
         idle_rd    <= 1'b1;
         last_grant <= 1'b1;
         exp_seq0   <= '0;
         exp_seq1   <= '0;
         data_rx    <= '0;
         valid_rx   <= 1'b0;
         dest_rx    <= 1'b0;
         rx_count0  <= '0;
         rx_count1  <= '0;
         err_count  <= '0;
         error_rx   <= 1'b0;
      end else begin
         state    <= state_nx;
         pop_D0   <= pop0_nx;
         pop_D1   <= pop1_nx;
         idle_rd  <= idle_nx;
         valid_rx <= in_flight;
         if (pop0_nx)      last_grant <= 1'b0;
         else if (pop1_nx) last_grant <= 1'b1;
         if (in_flight) begin
            data_rx <= word;
            dest_rx <= sel;
            // Expected sequence follows the received word so one gap costs one error.
            if (sel) begin
               rx_count1 <= rx_count1 + CNT_W'(1);
               exp_seq1  <= word[3:0] + 4'd1;
            end else begin
               rx_count0 <= rx_count0 + CNT_W'(1);
               exp_seq0  <= word[3:0] + 4'd1;
            end
            if (word_bad) begin
               error_rx <= 1'b1;
               if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/egress_reader.md
# egress_reader

Consumer at the output end of the interconnect device: drains the two destination FIFOs (D0, D1) by generating `pop_D0`/`pop_D1` from their empty flags, with round-robin arbitration when both hold data. Each word read is checked for destination tag and per-destination sequence, and is presented on a single egress port. The block replaces the hand-driven pop stimulus and is the read-side counterpart of the ingress `push_data_in` path.

## Interface
- `DATA_W`, 6: word width, equal to the D FIFO width.
- `CNT_W`, 8: width of the receive and error counters.

- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `enable`  in  1  1 = drain FIFOs, 0 = stop issuing pops; in-flight word still completes.
- `empty_D0`, `empty_D1`  in  1  FIFO empty flags; registered, updated the cycle after a pop.
- `data_out0`, `data_out1`  in  DATA_W  FIFO read data; valid the cycle after the matching pop.
- `pop_D0`, `pop_D1`  out  1  one-cycle read strobes; never both high.
- `data_rx`  out  DATA_W  captured word.
- `valid_rx`  out  1  one-cycle strobe qualifying `data_rx`/`dest_rx`.
- `dest_rx`  out  1  source FIFO of `data_rx` (0 = D0, 1 = D1).
- `rx_count0`, `rx_count1`  out  CNT_W  words received per FIFO, wrapping modulo 2^CNT_W.
- `err_count`  out  CNT_W  checker errors, saturating at 2^CNT_W-1.
- `error_rx`  out  1  sticky; set on first error, cleared only by reset.
- `idle_rd`  out  1  1 when in IDLE, or in RUN with both FIFOs empty and nothing in flight.

## Operation
- Word format: `data[4]` = destination tag, `data[3:0]` = sequence nibble, `data[5]` = VC bit (not checked).
- States:
  - IDLE: no pops. Goes to RUN when `enable`=1.
  - RUN: arbitration active. Goes to STOP when `enable`=0.
  - STOP: no new pops. Goes to IDLE once no word is in flight, i.e. the cycle after the last pop has been captured.
- Eligibility:
  - FIFO n is eligible when `empty_Dn`=0 and `pop_Dn` was not asserted in the previous cycle.
  - This one-cycle holdoff covers the stale empty flag, so the reader never pops an empty FIFO.
- Arbitration:
  - If only one FIFO is eligible, pop it.
  - If both are eligible, pop the one not granted last. `last_grant` resets to 1, so D0 wins the first tie.
  - `last_grant` updates only when a pop is issued.
- Capture:
  - The cycle after `pop_Dn`: `data_rx` <= `data_out{n}`, `dest_rx` <= n, `valid_rx`=1, and `rx_count{n}` increments.
- Checks, applied on each capture:
  - Tag error: `data[4]` != n.
  - Sequence error: `data[3:0]` != `exp_seq{n}`.
  - After every capture, `exp_seq{n}` <= `data[3:0]`+1 mod 16, so the checker resynchronises after a gap.
  - Tag and sequence errors on the same word count as one error: `err_count`+1 and `error_rx` set.
- Reset values: all outputs 0 except `idle_rd`=1. State = IDLE, `exp_seq0` = `exp_seq1` = 0, `last_grant` = 1.
- Reset mid-operation: any in-flight word is discarded (no `valid_rx`) and the pops stop at once.

## Timing
- Pop to `valid_rx`: 1 cycle. Pop decision is combinational from registered state and the empty flags; the pop outputs themselves are registered.
- `enable` rising: first pop possible on the second rising edge after `enable` is sampled high (one edge for IDLE to RUN, one for the registered pop).
- Throughput:
  - 1 word/cycle when both FIFOs are non-empty (alternating D0, D1).
  - 1 word per 2 cycles when a single FIFO holds data.
- `enable` falling: a pop already registered still completes and is captured. No pop is issued after the edge that samples `enable`=0.
- `idle_rd` is registered and is high the cycle after the last capture when both FIFOs are empty.

## Test plan
- Reset held low, then released with both FIFOs empty and `enable`=1 -> all outputs 0 except `idle_rd`=1, and `pop_D0`/`pop_D1` stay 0.
- D0 preloaded with 0x00..0x03, D1 empty -> pops on alternate cycles, `data_rx` = 0,1,2,3, `dest_rx`=0, `rx_count0`=4, `err_count`=0, then `idle_rd`=1.
- D0 = {0x00,0x01}, D1 = {0x10,0x11}, both non-empty at the same time -> pop order D0,D1,D0,D1 on consecutive cycles, and `valid_rx` high for 4 consecutive cycles.
- D0 = {0x00,0x02,0x03} -> one error at word 0x02, `err_count`=1, `error_rx`=1, and no error at 0x03 (resync).
- Word 0x15 placed in D0 -> tag error plus sequence error, counted once (`err_count`=1).
- `enable` dropped the cycle after `pop_D0` -> that word is still delivered, no further pops, state IDLE, `idle_rd`=1. Reset asserted with a pop in flight -> no `valid_rx`, all counters 0.
